dbus_sram_responder: RTL and testbench
======================================

Name: dbus_sram_responder

Overview:
- Simulation/FPGA-side responder for the data bus. Accepts one dbus_req_t at a time from the core's memory stage and returns dbus_resp_t.
- Backed by an internal 64-bit-wide word array with byte-strobe writes.
- Has a programmable fixed response latency, so the hazard unit's data_ok-driven stall paths can be exercised with realistic memory timing.

Parameters:
- DEPTH, 4096: number of 64-bit words; power of two.
- BASE, 64'h8000_0000: byte address of word 0.
- LATENCY, 2: cycles from acceptance to data_ok; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-low.
- dreq  in  dbus_req_t  fields: valid 1, addr 64, size 3 (msize_t), strobe 8, data 64.
- dresp  out  dbus_resp_t  fields: addr_ok 1, data_ok 1, data 64.
- err  out  1  sticky flag: an out-of-range or misaligned access occurred.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, counter=0, dresp all zero, err=0.
  - Memory contents are not cleared.
  - A reset asserted mid-transaction abandons the transaction: no pending write is committed, and data_ok is not raised.
- States:
  - IDLE: dresp.addr_ok=1, data_ok=0. If dreq.valid, latch addr/size/strobe/data, set counter=LATENCY-1, and go to WAIT.
    - Acceptance cycle = cycle 0.
    - With LATENCY==1, go directly to RESP.
  - WAIT: addr_ok=0. Decrement counter each cycle. When counter==1, go to RESP next edge.
  - RESP: data_ok=1 for exactly one cycle; data holds the registered read word. Return to IDLE next edge.
- data_ok timing:
  - data_ok is high exactly in cycle LATENCY after acceptance.
  - Throughput is one transaction per LATENCY+1 cycles.
  - The core holds dreq stable until it sees data_ok. In the RESP cycle the old request is still visible and must not be re-accepted; the next request is accepted only in the following IDLE cycle.
- Address decode:
  - index = (addr-BASE)[3 +: log2(DEPTH)].
  - In range iff BASE <= addr < BASE+8*DEPTH.
- Alignment:
  - size 0: any address.
  - size 1: addr[0]==0.
  - size 2: addr[1:0]==0.
  - size 3: addr[2:0]==0.
- Read (strobe==0):
  - mem[index] is sampled on the edge entering RESP and returned as the full 64-bit word.
  - Lane extraction is the core's job.
- Write (strobe!=0):
  - Committed on the edge ending the RESP cycle. Only bytes with strobe[i]==1 update, with data[8i+:8].
  - dresp.data during a write RESP = pre-write word (don't-care for the core).
- Error access (out of range or misaligned):
  - Handled with normal timing; data_ok still asserts.
  - Read data = 0; write dropped; err set to 1 and held until reset.
- Requests are ignored when dreq.valid==0 in IDLE. Outside IDLE the inputs are not sampled.
- No combinational path from dreq to dresp.

Decomposition:
- Into memory_pkg:
  - resp_state_t enum {IDLE, WAIT, RESP}.
  - Helper function addr_aligned(addr, size).
  - Constant DBUS_LAT_MAX=15.
- dbus_req_t, dbus_resp_t and msize_t stay in common.
- Sub-module: byte_strobe_ram (DEPTH x 64, 1 read + 1 strobed write port, registered read, write-first disabled), instantiated once.
- FSM, decode and err logic stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles with dreq.valid=1 → dresp.data_ok=0, addr_ok=0 during reset, err=0; after release, addr_ok=1 in IDLE.
- Write then read, LATENCY=2:
  - Write addr 0x8000_0010, size 3, strobe 8'hFF, data 64'h1122_3344_5566_7788 → data_ok high exactly 2 cycles after acceptance, for 1 cycle.
  - Read of the same address → data 64'h1122_3344_5566_7788.
- Partial strobe:
  - Preload 0x8000_0018 with 64'hFFFF_FFFF_FFFF_FFFF.
  - Write strobe 8'h0C, data 64'h0000_0000_AABB_0000 → read returns 64'hFFFF_FFFF_AABB_FFFF.
- Back-to-back, LATENCY=1:
  - Core holds each request until data_ok and presents the next immediately.
  - 4 reads complete at cycles 1, 3, 5, 7 → no duplicate acceptance in RESP cycles.
- Error cases:
  - Read 0x7FFF_FFF8 → data 0, data_ok on time, err=1.
  - Write size 2 at 0x8000_0002 → memory unchanged, err stays 1.
- Reset mid-transaction:
  - Accept write to 0x8000_0020, then assert reset in the WAIT cycle.
  - After release, read 0x8000_0020 → old contents, no data_ok during reset.

Source files
------------

// File: rtl/dbus_sram_responder_pkg.sv
// Shared types and helpers for the data-bus SRAM responder.
// Bus request/response types, the responder state encoding and the
// alignment check used by the address decoder.
package dbus_sram_responder_pkg;

   // Access size encoding: 1, 2, 4 or 8 bytes.
   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_state_t;

   localparam int DBUS_LAT_MAX = 15;

   // Natural alignment check; only the low three address bits matter.
   // Encodings above MSIZE8 are treated as misaligned.
   function automatic logic addr_aligned(input logic [2:0] addr, input msize_t size);
      logic ok;
      case (size)
         MSIZE1:  ok = 1'b1;
         MSIZE2:  ok = (addr[0] == 1'b0);
         MSIZE4:  ok = (addr[1:0] == 2'b00);
         MSIZE8:  ok = (addr[2:0] == 3'b000);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus connection between the core's memory stage (master) and the
// SRAM responder (slave).
interface dbus_sram_responder_if;
   import dbus_sram_responder_pkg::*;

   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_sram_responder_ram.sv
// DEPTH x 64-bit word array with one registered read port and one
// byte-strobed write port. A read and a write to the same word in the
// same cycle return the old contents.
module byte_strobe_ram #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wstrb,
   input  logic [63:0]   wdata
);

   logic [63:0] mem_r [DEPTH];
   logic [63:0] rdata_r;

   // Byte-lane write: only lanes with their strobe bit set are updated.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (wstrb[i]) begin
               mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   // Registered read, captured only when a read is requested.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/dbus_sram_responder.sv
// Fixed-latency SRAM responder for the data bus. Accepts one request at a
// time, answers with data_ok exactly LATENCY cycles after acceptance, and
// flags out-of-range or misaligned accesses on a sticky err output.
module dbus_sram_responder
   import dbus_sram_responder_pkg::*;
#(
   parameter int          DEPTH   = 4096,
   parameter logic [63:0] BASE    = 64'h8000_0000,
   parameter int          LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   dbus_sram_responder_if.slave bus,
   output logic                 err
);

   localparam int            AW   = $clog2(DEPTH);
   localparam int            CW   = $clog2(DBUS_LAT_MAX + 1);
   localparam logic [63:0]   SPAN = 64'(DEPTH) * 64'd8;
   localparam logic [CW-1:0] LOAD = CW'(LATENCY - 1);

   resp_state_t   state_r;
   logic [CW-1:0] count_r;
   logic          addr_ok_r;
   logic          data_ok_r;
   logic          err_r;
   logic          bad_r;
   logic [AW-1:0] idx_r;
   logic [7:0]    strobe_r;
   logic [63:0]   wdata_r;

   logic [63:0]   req_off_s;
   logic [AW-1:0] req_idx_s;
   logic          req_bad_s;
   logic          enter_resp_s;
   logic          ram_we_s;
   logic [AW-1:0] ram_raddr_s;
   logic [63:0]   ram_rdata_s;
   logic [63:0]   resp_data_s;

   // Decode the presented request: word index and error classification.
   always_comb begin
      req_off_s = bus.dreq.addr - BASE;
      req_idx_s = req_off_s[3 +: AW];
      req_bad_s = (bus.dreq.addr < BASE) || (req_off_s >= SPAN) ||
                  !addr_aligned(bus.dreq.addr[2:0], bus.dreq.size);
   end

   // RAM control: read fires on the edge entering RESP, write on the edge leaving it.
   always_comb begin
      enter_resp_s = 1'b0;
      ram_raddr_s  = idx_r;
      case (state_r)
         IDLE: begin
            // With single-cycle latency the request is read straight off the bus.
            ram_raddr_s = req_idx_s;
            if (bus.dreq.valid && (LATENCY == 1)) begin
               enter_resp_s = 1'b1;
            end else begin
               enter_resp_s = 1'b0;
            end
         end
         WAIT: begin
            if (count_r == CW'(1)) begin
               enter_resp_s = 1'b1;
            end else begin
               enter_resp_s = 1'b0;
            end
         end
         RESP:    enter_resp_s = 1'b0;
         default: enter_resp_s = 1'b0;
      endcase
      // Reset abandons the transaction, so a pending write is never committed.
      if (reset && (state_r == RESP) && (strobe_r != 8'h00) && !bad_r) begin
         ram_we_s = 1'b1;
      end else begin
         ram_we_s = 1'b0;
      end
   end

   // Responder FSM with registered handshake outputs and sticky error flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= IDLE;
         count_r   <= '0;
         addr_ok_r <= 1'b0;
         data_ok_r <= 1'b0;
         err_r     <= 1'b0;
         bad_r     <= 1'b0;
         idx_r     <= '0;
         strobe_r  <= 8'h00;
         wdata_r   <= 64'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.dreq.valid) begin
                  idx_r     <= req_idx_s;
                  strobe_r  <= bus.dreq.strobe;
                  wdata_r   <= bus.dreq.data;
                  bad_r     <= req_bad_s;
                  count_r   <= LOAD;
                  addr_ok_r <= 1'b0;
                  if (LATENCY == 1) begin
                     state_r   <= RESP;
                     data_ok_r <= 1'b1;
                     err_r     <= err_r | req_bad_s;
                  end else begin
                     state_r   <= WAIT;
                  end
               end else begin
                  addr_ok_r <= 1'b1;
               end
            end
            WAIT: begin
               count_r <= count_r - CW'(1);
               if (count_r == CW'(1)) begin
                  state_r   <= RESP;
                  data_ok_r <= 1'b1;
                  err_r     <= err_r | bad_r;
               end
            end
            RESP: begin
               // Old request is still on the bus here; it is not re-sampled.
               state_r   <= IDLE;
               data_ok_r <= 1'b0;
               addr_ok_r <= 1'b1;
            end
            default: begin
               state_r   <= IDLE;
               data_ok_r <= 1'b0;
               addr_ok_r <= 1'b0;
            end
         endcase
      end
   end

   byte_strobe_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .re    (enter_resp_s),
      .raddr (ram_raddr_s),
      .rdata (ram_rdata_s),
      .we    (ram_we_s),
      .waddr (idx_r),
      .wstrb (strobe_r),
      .wdata (wdata_r)
   );

   // Response data is the RAM word in RESP, forced to zero for error accesses.
   always_comb begin
      if (data_ok_r && !bad_r) begin
         resp_data_s = ram_rdata_s;
      end else begin
         resp_data_s = 64'd0;
      end
   end

   assign bus.dresp = '{addr_ok: addr_ok_r, data_ok: data_ok_r, data: resp_data_s};
   assign err       = err_r;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench for dbus_sram_responder: one instance with LATENCY=2
// and one with LATENCY=1. Stimulus pushes expected responses; a negedge
// monitor pops and compares whenever data_ok is seen.
module tb_dbus_sram_responder;
   import dbus_sram_responder_pkg::*;

   typedef struct {
      logic [63:0] data;
      logic        chk_data;
      int          due;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic err1;
   logic err2;
   int   cyc    = 0;
   int   tests  = 0;
   int   failed = 0;
   int   t_first;
   int   t_last;
   exp_t q1[$];
   exp_t q2[$];

   dbus_sram_responder_if if1();
   dbus_sram_responder_if if2();

   dbus_sram_responder #(.DEPTH(4096), .BASE(64'h8000_0000), .LATENCY(2)) dut2 (
      .clk(clk), .reset(reset), .bus(if2), .err(err2));

   dbus_sram_responder #(.DEPTH(4096), .BASE(64'h8000_0000), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .bus(if1), .err(err1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every data_ok cycle must match the oldest expected response.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (if2.dresp.data_ok === 1'b1) begin
         if (q2.size() == 0) begin
            tests++; failed++;
            $display("FAIL lat2_unexpected_data_ok: got data_ok=1, want 0 (cycle %0d)", cyc);
         end else begin
            e = q2.pop_front();
            chk("lat2_timing", 64'(cyc), 64'(e.due));
            if (e.chk_data) chk("lat2_data", if2.dresp.data, e.data);
            chk("lat2_err", 64'(err2), 64'(e.err));
         end
      end
      if (if1.dresp.data_ok === 1'b1) begin
         if (q1.size() == 0) begin
            tests++; failed++;
            $display("FAIL lat1_unexpected_data_ok: got data_ok=1, want 0 (cycle %0d)", cyc);
         end else begin
            e = q1.pop_front();
            chk("lat1_timing", 64'(cyc), 64'(e.due));
            if (e.chk_data) chk("lat1_data", if1.dresp.data, e.data);
            chk("lat1_err", 64'(err1), 64'(e.err));
         end
      end
   end

   // Present a request in the next cycle, queue its expectation, hold until data_ok.
   task automatic issue(input int lat, input logic [63:0] a, input msize_t sz,
                        input logic [7:0] st, input logic [63:0] d,
                        input logic chk_data, input logic [63:0] exp_data, input logic exp_err);
      exp_t e;
      logic seen;
      @(posedge clk); #1;
      e.data = exp_data; e.chk_data = chk_data; e.due = cyc + lat; e.err = exp_err;
      if (lat == 1) begin
         if1.dreq = '{valid: 1'b1, addr: a, size: sz, strobe: st, data: d};
         q1.push_back(e);
      end else begin
         if2.dreq = '{valid: 1'b1, addr: a, size: sz, strobe: st, data: d};
         q2.push_back(e);
      end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = (lat == 1) ? if1.dresp.data_ok : if2.dresp.data_ok;
      end
      if (!seen) begin
         tests++; failed++;
         $display("FAIL data_ok_timeout: got no data_ok for addr %h, want one within 20 cycles", a);
      end
   endtask

   task automatic park();
      @(posedge clk); #1;
      if1.dreq.valid = 1'b0;
      if2.dreq.valid = 1'b0;
   endtask

   task automatic wr(input int lat, input logic [63:0] a, input logic [7:0] st,
                     input logic [63:0] d, input logic exp_err);
      issue(lat, a, MSIZE8, st, d, 1'b0, 64'd0, exp_err);
   endtask

   task automatic rd(input int lat, input logic [63:0] a, input msize_t sz,
                     input logic [63:0] exp_data, input logic exp_err);
      issue(lat, a, sz, 8'h00, 64'd0, 1'b1, exp_data, exp_err);
   endtask

   initial begin
      // Reset held with a valid request on both buses.
      reset = 1'b0;
      if1.dreq = '{valid: 1'b1, addr: 64'h8000_0000, size: MSIZE8, strobe: 8'hFF, data: 64'hFFFF_FFFF_FFFF_FFFF};
      if2.dreq = '{valid: 1'b1, addr: 64'h8000_0000, size: MSIZE8, strobe: 8'hFF, data: 64'hFFFF_FFFF_FFFF_FFFF};
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset_data_ok", 64'(if2.dresp.data_ok), 64'd0);
         chk("reset_addr_ok", 64'(if2.dresp.addr_ok), 64'd0);
         chk("reset_err", 64'(err2), 64'd0);
         chk("reset_data_ok_lat1", 64'(if1.dresp.data_ok), 64'd0);
      end
      @(posedge clk); #1;
      if1.dreq.valid = 1'b0;
      if2.dreq.valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("idle_addr_ok", 64'(if2.dresp.addr_ok), 64'd1);
      chk("idle_addr_ok_lat1", 64'(if1.dresp.addr_ok), 64'd1);
      chk("idle_err", 64'(err2), 64'd0);

      // LATENCY=2: full write, read back, edge-byte strobes.
      wr(2, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
      rd(2, 64'h8000_0010, MSIZE8, 64'h1122_3344_5566_7788, 1'b0);
      wr(2, 64'h8000_0010, 8'h81, 64'hAA00_0000_0000_0055, 1'b0);
      rd(2, 64'h8000_0010, MSIZE8, 64'hAA22_3344_5566_7755, 1'b0);
      // Partial strobe on a preloaded all-ones word.
      wr(2, 64'h8000_0018, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      wr(2, 64'h8000_0018, 8'h0C, 64'h0000_0000_AABB_0000, 1'b0);
      rd(2, 64'h8000_0018, MSIZE8, 64'hFFFF_FFFF_AABB_FFFF, 1'b0);
      // First and last in-range words, plus a word for the reset test.
      wr(2, 64'h8000_0000, 8'hFF, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
      wr(2, 64'h8000_7FF8, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b0);
      wr(2, 64'h8000_0020, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
      rd(2, 64'h8000_7FF8, MSIZE8, 64'hCAFE_F00D_1234_5678, 1'b0);
      // Narrow aligned reads return the full containing word.
      rd(2, 64'h8000_0013, MSIZE1, 64'hAA22_3344_5566_7755, 1'b0);
      rd(2, 64'h8000_0006, MSIZE2, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
      rd(2, 64'h8000_0004, MSIZE4, 64'h0F0E_0D0C_0B0A_0908, 1'b0);

      // Error accesses: below base, one past the end, misaligned writes.
      rd(2, 64'h7FFF_FFF8, MSIZE8, 64'd0, 1'b1);
      rd(2, 64'h8000_8000, MSIZE8, 64'd0, 1'b1);
      issue(2, 64'h8000_0002, MSIZE4, 8'h0F, 64'h1111_1111_1111_1111, 1'b0, 64'd0, 1'b1);
      rd(2, 64'h8000_0000, MSIZE8, 64'h0F0E_0D0C_0B0A_0908, 1'b1);
      wr(2, 64'h8000_0014, 8'hFF, 64'h2222_2222_2222_2222, 1'b1);
      rd(2, 64'h8000_0010, MSIZE8, 64'hAA22_3344_5566_7755, 1'b1);
      park();

      // Reset during WAIT abandons the accepted write.
      @(posedge clk); #1;
      if2.dreq = '{valid: 1'b1, addr: 64'h8000_0020, size: MSIZE8, strobe: 8'hFF, data: 64'hDEAD_BEEF_DEAD_BEEF};
      @(posedge clk); #1;
      reset = 1'b0;
      if2.dreq.valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midreset_data_ok", 64'(if2.dresp.data_ok), 64'd0);
      end
      chk("midreset_err_cleared", 64'(err2), 64'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      rd(2, 64'h8000_0020, MSIZE8, 64'h0123_4567_89AB_CDEF, 1'b0);
      park();

      // LATENCY=1 back-to-back: writes then four reads completing every other cycle.
      for (int k = 0; k < 4; k++) begin
         wr(1, 64'h8000_0100 + 64'(8 * k), 8'hFF, 64'hA5A5_0000_0000_0000 + 64'(k), 1'b0);
      end
      for (int k = 0; k < 4; k++) begin
         rd(1, 64'h8000_0100 + 64'(8 * k), MSIZE8, 64'hA5A5_0000_0000_0000 + 64'(k), 1'b0);
         if (k == 0) t_first = cyc;
         t_last = cyc;
      end
      chk("lat1_b2b_span", 64'(t_last - t_first), 64'd6);
      rd(1, 64'h7FFF_FFF8, MSIZE8, 64'd0, 1'b1);
      park();

      repeat (3) @(posedge clk);
      chk("q2_drained", 64'(q2.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
